// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and decode helpers for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMREAD = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECR   = 4'd7,
    EXECI   = 4'd8,
    ALUWB   = 4'd9,
    BEQ     = 4'd10,
    JAL     = 4'd11,
    TRAP    = 4'd12
  } state_e;

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA / ALUSrcB
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format implied by the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_src_f(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Funct3 values the ALU decoder actually implements.
  function automatic logic funct3_alu_ok_f(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State that follows DECODE; anything unsupported lands in TRAP.
  function automatic state_e decode_next_f(input logic [6:0] op, input logic [2:0] f3);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = MEMADR;
      OP_R:         nxt = funct3_alu_ok_f(f3) ? EXECR : TRAP;
      OP_I:         nxt = funct3_alu_ok_f(f3) ? EXECI : TRAP;
      OP_BEQ:       nxt = (f3 == 3'b000) ? BEQ : TRAP;
      OP_JAL:       nxt = JAL;
      default:      nxt = TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp and instruction fields to ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Select the ALU operation; only register-register forms may subtract.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op5_i && funct7b5_i) alu_control_o = ALU_SUB;
            else                     alu_control_o = ALU_ADD;
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM with memory request/ready handshake and retire counter.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             Funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       alu_op_s;
  logic             retire_s;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct3_i      (Funct3),
    .op5_i         (Op[5]),
    .funct7b5_i    (Funct7b5),
    .alu_control_o (ALUControl)
  );

  // State and retire-counter registers; reset abandons any instruction in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath controls; MemReady and Zero are the only Mealy terms.
  always_comb begin
    state_d   = state_q;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_I;
    Illegal   = 1'b0;
    alu_op_s  = ALUOP_ADD;
    retire_s  = 1'b0;

    // IDLE drives every output low, including the immediate format.
    if (state_q == IDLE) ImmSrc = IMM_I;
    else                 ImmSrc = imm_src_f(Op);

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = DECODE;
        else          state_d = FETCH;
      end
      DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = decode_next_f(Op, Funct3);
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        if (Op == OP_LW) state_d = MEMREAD;
        else             state_d = MEMWR;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_d = MEMWB;
        else          state_d = MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RES_READDATA;
        RegWrite  = 1'b1;
        retire_s  = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (MemReady) begin
          retire_s = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = MEMWR;
        end
      end
      EXECR: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        alu_op_s = ALUOP_FUNCT;
        state_d  = ALUWB;
      end
      EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
        state_d  = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        retire_s = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        alu_op_s = ALUOP_SUB;
        PCWrite  = Zero;
        retire_s = 1'b1;
        state_d  = FETCH;
      end
      JAL: begin
        // Jump target from ALUOut into PC while PC+4 is formed for rd.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      TRAP: begin
        Illegal = 1'b1;
        state_d = TRAP;
      end
      default: begin
        // Corrupted state encoding is treated like an illegal instruction.
        Illegal = 1'b1;
        state_d = TRAP;
      end
    endcase

    if (retire_s) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          cnt_d = cnt_q;
  end

  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit (32-bit and 4-bit counters).
module tb_multicycle_control_unit;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JP  = 7'b1101111;

  typedef struct packed {
    logic [17:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [6:0] Op;
  logic [2:0] Funct3;
  logic       Funct7b5, Zero, MemReady;

  logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [31:0] InstrCount;

  logic m4_MemReq, m4_MemWrite, m4_AdrSrc, m4_IRWrite, m4_PCWrite, m4_RegWrite, m4_Illegal;
  logic [1:0] m4_ResultSrc, m4_ALUSrcA, m4_ALUSrcB, m4_ImmSrc;
  logic [2:0] m4_ALUControl;
  logic [3:0] InstrCount4;

  logic [17:0] act, act4;
  assign act  = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
  assign act4 = {m4_MemReq, m4_MemWrite, m4_AdrSrc, m4_IRWrite, m4_PCWrite, m4_RegWrite,
                 m4_ResultSrc, m4_ALUSrcA, m4_ALUSrcB, m4_ImmSrc, m4_ALUControl, m4_Illegal};

  multicycle_control_unit dut (
    .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Illegal(Illegal), .InstrCount(InstrCount)
  );

  multicycle_control_unit #(.CNT_W(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(m4_MemReq), .MemWrite(m4_MemWrite),
    .AdrSrc(m4_AdrSrc), .IRWrite(m4_IRWrite), .PCWrite(m4_PCWrite), .RegWrite(m4_RegWrite),
    .ResultSrc(m4_ResultSrc), .ALUSrcA(m4_ALUSrcA), .ALUSrcB(m4_ALUSrcB), .ImmSrc(m4_ImmSrc),
    .ALUControl(m4_ALUControl), .Illegal(m4_Illegal), .InstrCount(InstrCount4)
  );

  always #5 Clk = ~Clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q[$];
  logic [31:0] cnt_model;
  logic [1:0]  exp_imm;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Immediate format each instruction class needs.
  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW)      return 2'b01;
    else if (op == BR) return 2'b10;
    else if (op == JP) return 2'b11;
    else               return 2'b00;
  endfunction

  // Which encodings the core supports.
  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    if (op == LW || op == SW || op == JP) return 1'b1;
    if (op == RT || op == IT) return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
    if (op == BR) return (f3 == 3'd0);
    return 1'b0;
  endfunction

  // Arithmetic the instruction itself asks for.
  function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0)      return (op == RT && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'd2) return 3'b101;
    else if (f3 == 3'd6) return 3'b011;
    else                 return 3'b010;
  endfunction

  function automatic logic [17:0] mk(input logic mreq, input logic mw, input logic adr,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic ill);
    return {mreq, mw, adr, ir, pc, rw, rs, sa, sb, exp_imm, alu, ill};
  endfunction

  task automatic cyc(input logic mr, input logic z, input logic [17:0] e);
    exp_t t;
    MemReady = mr;
    Zero     = z;
    t.ctl    = e;
    t.cnt    = cnt_model;
    q.push_back(t);
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    Rst_n     = 1'b0;
    cnt_model = 32'd0;
    for (int i = 0; i < n; i++) cyc(rb(), rb(), 18'd0);
    Rst_n = 1'b1;
    cyc(rb(), rb(), 18'd0);
  endtask

  task automatic wb();
    cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input int fst, input int mst, input logic zv, input logic abort);
    logic mw;
    Op       = op;
    Funct3   = f3;
    Funct7b5 = f7;
    exp_imm  = imm_of(op);
    for (int i = 0; i < fst; i++)
      cyc(1'b0, rb(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0));
    cyc(1'b1, rb(), mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0));
    cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0));
    if (!legal(op, f3)) begin
      for (int i = 0; i < 10; i++)
        cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
      reset_pulse(2);
      return;
    end
    if (op == LW || op == SW) begin
      mw = (op == SW);
      cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0));
      for (int i = 0; i < mst; i++)
        cyc(1'b0, rb(), mk(1'b1, mw, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
      if (abort) begin
        reset_pulse(2);
        return;
      end
      cyc(1'b1, rb(), mk(1'b1, mw, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
      if (!mw)
        cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));
    end else if (op == BR) begin
      cyc(rb(), zv, mk(1'b0, 1'b0, 1'b0, 1'b0, zv, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0));
    end else if (op == JP) begin
      cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0));
      wb();
    end else begin
      cyc(rb(), rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                         (op == RT) ? 2'b00 : 2'b01, alu_of(op, f3, f7), 1'b0));
      wb();
    end
    cnt_model = cnt_model + 32'd1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_cmp = n_cmp + 4;
      if (act !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl t=%0t got %h expected %h", $time, act, e.ctl);
      end
      if (act4 !== e.ctl) begin
        n_bad++;
        $display("FAIL ctl4 t=%0t got %h expected %h", $time, act4, e.ctl);
      end
      if (InstrCount !== e.cnt) begin
        n_bad++;
        $display("FAIL count t=%0t got %0d expected %0d", $time, InstrCount, e.cnt);
      end
      if (InstrCount4 !== e.cnt[3:0]) begin
        n_bad++;
        $display("FAIL count4 t=%0t got %0d expected %0d", $time, InstrCount4, e.cnt[3:0]);
      end
    end
  end

  // Stimulus: directed scenarios followed by a random instruction stream.
  initial begin : stim
    logic [2:0] lf3 [4];
    logic [6:0] op;
    logic [2:0] f3;
    int         k;
    lf3[0] = 3'd0; lf3[1] = 3'd2; lf3[2] = 3'd6; lf3[3] = 3'd7;
    Rst_n = 1'b0; Op = 7'd0; Funct3 = 3'd0; Funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    cnt_model = 32'd0; exp_imm = 2'b00;
    @(posedge Clk);
    #1;
    reset_pulse(2);

    do_instr(LW, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr(SW, 3'd2, 1'b0, 0, 3, 1'b0, 1'b0);
    do_instr(BR, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0);
    do_instr(BR, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr(RT, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
    do_instr(IT, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
    do_instr(RT, 3'd7, 1'b0, 1, 0, 1'b0, 1'b0);
    do_instr(RT, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr(JP, 3'd0, 1'b0, 2, 0, 1'b0, 1'b0);
    do_instr(7'b1110011, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    do_instr(LW, 3'd2, 1'b0, 0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) do_instr(IT, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 19);
      f3 = 3'($urandom_range(0, 7));
      if (k <= 2)       op = LW;
      else if (k <= 5)  op = SW;
      else if (k <= 9)  begin op = RT; f3 = lf3[$urandom_range(0, 3)]; end
      else if (k <= 13) begin op = IT; f3 = lf3[$urandom_range(0, 3)]; end
      else if (k <= 15) begin op = BR; if ($urandom_range(0, 7) != 0) f3 = 3'd0; end
      else if (k <= 17) op = JP;
      else if (k == 18) op = 7'($urandom_range(0, 127));
      else              op = IT;
      do_instr(op, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), 1'b0);
    end

    @(posedge Clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control FSM for the multicycle RISC-V core. It drives the datapath's mux selects, write enables and ALUControl from the latched instruction fields and the ALU Zero flag.
- It adds a request/ready handshake to the shared instruction/data memory.
- It supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.
- Any other encoding traps.

Parameters:
- CNT_W, 32, width of retired-instruction counter InstrCount.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- Op  input  7  opcode from instruction register (stable after IRWrite).
- Funct3  input  3  instr[14:12].
- Funct7b5  input  1  instr[30].
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes current access this cycle.
- MemReq  output  1  memory access request.
- MemWrite  output  1  store strobe; valid only with MemReq.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  load instruction register and OldPC.
- PCWrite  output  1  load PC from Result.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  Result select: 00 ALUOut, 01 ReadData, 10 ALUResult.
- ALUSrcA  output  2  SrcA select: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  output  2  SrcB select: 00 RD2, 01 ImmExt, 10 constant 4.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- Illegal  output  1  trap state indicator.
- InstrCount  output  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - Rst_n=0 forces state IDLE and InstrCount=0.
  - In IDLE all outputs are 0.
  - The first edge after release moves the FSM to FETCH.
  - Reset mid-instruction abandons that instruction; no partial write is completed after release.
- Outputs are combinational from state, with two Mealy terms: MemReady and Zero.
- Signals not listed for a state are 0.
- ImmSrc is decoded from Op in every state:
  - lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- ALUOp (internal, 2 bits) drives the ALU decoder:
  - 00: add.
  - 01: sub.
  - 10: by Funct3.
    - 000: sub if Op[5]&Funct7b5, else add. addi never subtracts.
    - 010: slt.
    - 110: or.
    - 111: and.
- State behaviour:
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
    - IRWrite=PCWrite=MemReady.
    - Stays in FETCH while MemReady=0; goes to DECODE on MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
    - lw/sw → MEMADR; R → EXECR; I-ALU → EXECI; beq → BEQ; jal → JAL.
    - Unsupported Op, or R/I Funct3 outside {000,010,110,111}, or beq Funct3≠000 → TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWR.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Holds until MemReady, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. → FETCH.
  - MEMWR: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Holds until MemReady, then → FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. → ALUWB (rd=PC+4).
  - TRAP: Illegal=1. Absorbing state; only reset exits.
- Latency with MemReady held at 1:
  - lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles.
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWR adds one cycle.
- Handshake:
  - Once MemReq is raised, MemReq, AdrSrc and MemWrite stay constant until the MemReady cycle.
  - MemReady while MemReq=0 is ignored.
- InstrCount:
  - Increments by 1 on each edge leaving MEMWB, ALUWB or BEQ, and on leaving MEMWR with MemReady=1.
  - Wraps modulo 2^CNT_W.
  - Does not increment in TRAP.

Decomposition:
- Package riscv_ctrl_pkg contains:
  - State enum: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
  - Opcode constants: 0000011, 0100011, 0110011, 0010011, 1100011, 1101111.
  - ALUControl, ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- Sub-module alu_decoder (inputs ALUOp, Funct3, Op[5], Funct7b5; output ALUControl) is purely combinational.
- FSM, next-state logic and counter live in the top module.

Test Plan:
- lw, Op=0000011, MemReady=1 → FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - RegWrite=1 with ResultSrc=01 in cycle 5 only.
  - InstrCount 0→1.
- sw with MemReady low for 3 cycles in MEMWR → MemReq=MemWrite=1, AdrSrc=1 held 4 cycles; exit to FETCH on the 4th cycle; InstrCount +1 once.
- beq with Zero=1, then Zero=0 → PCWrite=1 in BEQ cycle, then PCWrite=0; both take 3 cycles.
- R-type Funct3=000 with Funct7b5=1 → ALUControl=001 in EXECR.
  - addi with Funct7b5=1 → ALUControl=000.
  - Funct3=111 → 010; Funct3=010 → 101.
- Op=1110011 → TRAP after DECODE; Illegal=1 and all enables 0 for 10 cycles; Rst_n pulse → IDLE, Illegal=0, InstrCount=0.
- Rst_n asserted asynchronously mid-MEMREAD → outputs 0 immediately, no RegWrite; restart FETCH one edge after release.
- CNT_W=4, 16 addi → InstrCount wraps 15→0.
